gpu_circle_ctrl: RTL and testbench
==================================

# gpu_circle_ctrl

Sequencer that draws a full or partial circle outline by driving the octant-draw engine through up to eight octants, one after another. It accepts a circle command over a valid/ready handshake and converts the engine's per-octant point stream into framebuffer write strobes. It also reports completion, pixel count and a watchdog error. It sits between the GPU command decoder and the octant-draw engine / framebuffer write port.

## Interface
- `MAX_RAD`, default `` `WIDTH/2 ``: largest accepted radius. A larger radius is rejected.
- `WD_SLACK`, default 4: watchdog cycles allowed beyond `rad` per octant.
- `clk` in 1: clock.
- `n_rst` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: controller idle and able to accept a command.
- `xC` in `` `WIDTH_BITS ``: centre x.
- `yC` in `` `HEIGHT_BITS ``: centre y.
- `rad` in `` `WIDTH_BITS ``: radius.
- `oct_mask` in 8: bit n set means draw octant n.
- `eng_oct` out 3: octant select to the engine.
- `eng_start` out 1: engine start. It is a level and must stay high for the whole octant.
- `eng_done` in 1: engine done flag.
- `eng_busy` in 1: engine busy flag.
- `eng_x` in `` `WIDTH_BITS ``: engine point x.
- `eng_y` in `` `HEIGHT_BITS ``: engine point y.
- `px_we` out 1: one-cycle pixel write strobe.
- `px_x` out `` `WIDTH_BITS ``: pixel x, registered.
- `px_y` out `` `HEIGHT_BITS ``: pixel y, registered.
- `done_o` out 1: one-cycle pulse when the command completes.
- `err_o` out 1: sticky error. Cleared when the next command is accepted.
- `pix_cnt` out 16: pixels written for the last command. Saturates at 16'hFFFF.

## Operation
- States: IDLE, LAUNCH, RUN, GAP, POINT, FINISH.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch `xC`, `yC`, `rad`, `oct_mask`, clear `pix_cnt` and `err_o`, and set the octant index to the lowest set mask bit.
  - If `oct_mask`==0, go to FINISH.
  - If `rad` > `MAX_RAD`, set `err_o` and go to FINISH.
  - If `rad`==0, go to POINT.
  - Otherwise go to LAUNCH.
- POINT: emit one pixel at (xC, yC), then go to FINISH.
- LAUNCH:
  - `eng_start`=1 and `eng_oct`=index. Load the watchdog with `rad`+`WD_SLACK`.
  - Go to RUN on the next cycle.
- RUN:
  - `eng_start` held at 1.
  - Every cycle with `eng_busy`=1, capture (`eng_x`, `eng_y`) as a candidate pixel.
  - When `eng_done`=1, drop `eng_start` and go to GAP.
  - The watchdog decrements each RUN cycle. At 0: set `err_o`, drop `eng_start`, go to FINISH.
- GAP:
  - `eng_start`=0 for exactly one cycle, which guarantees a fresh rising edge for the next octant.
  - Advance to the next set mask bit above the current index. If one exists go to LAUNCH, otherwise go to FINISH.
- FINISH: pulse `done_o`, then go to IDLE.
- Octants are processed in ascending index order, skipping cleared bits.
- Duplicate boundary pixels between adjacent octants are written as-is.
- `pix_cnt` increments once per `px_we`.
- Commands arriving while not IDLE are held off by `cmd_ready`=0 and are never dropped.
- Reset mid-command:
  - All state returns to IDLE and `eng_start` goes low immediately.
  - The engine re-synchronises on the next rising edge of `eng_start`.

## Timing
- Reset values:
  - `cmd_ready`=1.
  - `eng_start`=0, `eng_oct`=0.
  - `px_we`=0, `px_x`=0, `px_y`=0.
  - `done_o`=0, `err_o`=0, `pix_cnt`=0.
- Command acceptance happens in the cycle with `cmd_valid`&&`cmd_ready`. `eng_start` rises on the following edge.
- Pixel latency: `px_we`/`px_x`/`px_y` appear one cycle after the engine point is sampled.
- Inter-octant gap: one cycle low on `eng_start` between octants.
- `done_o` asserts one cycle after the last GAP, or immediately after POINT or an abort.
- `cmd_ready` returns high in the cycle after `done_o`.

## Configuration
- Macro: `GPU_CIRCLE_CLIP_EN`.
- When defined, a candidate pixel is discarded (no `px_we`, no count) if it wrapped or falls off-screen:
  - For octants that add to x, discard when `eng_x` < xC or `eng_x` ≥ `` `WIDTH ``.
  - For octants that subtract from x, discard when `eng_x` > xC.
  - The same rules apply to y against yC and `` `HEIGHT ``.
- When undefined, every candidate pixel is written, including wrapped coordinates.

## Structure
- Shared package `gpu_circle_pkg`:
  - State enum `circle_state_t`.
  - Octant sign table: per-octant x_add/y_add bits used by the clip logic.
- Width macros come from `gpu_definitions.vh`.
- One natural sub-module: `gpu_octant_clip`, a pure check that takes octant, centre and point and returns keep/drop. It is instantiated only under `GPU_CIRCLE_CLIP_EN`.

## Test plan
- Reset held mid-RUN:
  - `eng_start`, `px_we` and `done_o` go to 0 within the reset.
  - After release, `cmd_ready`=1.
- xC=100, yC=100, rad=5, mask=8'h01:
  - One octant drawn.
  - First pixel written is (105,100).
  - `done_o` pulses once.
  - `pix_cnt` equals the number of points the engine produced.
- Full circle, rad=10, mask=8'hFF:
  - 8 LAUNCHes in order 0..7, each followed by exactly one GAP cycle.
  - Each pixel satisfies |dx|²+|dy|² within ±10 of 100.
- rad=0, mask=8'hFF:
  - Exactly one `px_we` at (xC,yC).
  - `eng_start` never rises.
  - `pix_cnt`=1.
- Engine model never asserts done, rad=6:
  - `err_o` set after 10 RUN cycles.
  - `done_o` pulses.
  - `cmd_ready` returns high.
- With `GPU_CIRCLE_CLIP_EN`, xC=2, yC=50, rad=8, mask=8'h18 (octants 3,4):
  - No pixel is written with `px_x` > 2.
  - Without the macro, wrapped x values near `` `WIDTH``-6 do appear.

Source files
------------

// File: rtl/gpu_circle_pkg.sv
// Shared types and tables for the circle sequencer.
// Optional clip feature: GPU_CIRCLE_CLIP_EN (see gpu_circle_ctrl.sv).
`ifndef WIDTH
`define WIDTH 1024
`endif
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT
`define HEIGHT 600
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 10
`endif

package gpu_circle_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_GAP    = 3'd3,
        S_POINT  = 3'd4,
        S_FINISH = 3'd5
    } circle_state_t;

    // Bit n set: octant n moves away from the centre in +x / +y.
    localparam logic [7:0] OCT_X_ADD = 8'b1100_0011;
    localparam logic [7:0] OCT_Y_ADD = 8'b1111_0000;

    // Lowest set bit of mask at or above index 'from'; bit 3 of the result flags "none".
    function automatic logic [3:0] next_oct(input logic [7:0] mask, input logic [3:0] from);
        logic [3:0] r;
        r = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= from)) r = 4'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/gpu_octant_clip.sv
// Keep/drop check for one engine point against centre and screen edges.
`ifndef WIDTH
`define WIDTH 1024
`endif
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT
`define HEIGHT 600
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 10
`endif

module gpu_octant_clip
    import gpu_circle_pkg::*;
(
    input  logic [2:0]              oct,
    input  logic [`WIDTH_BITS-1:0]  xc,
    input  logic [`HEIGHT_BITS-1:0] yc,
    input  logic [`WIDTH_BITS-1:0]  x,
    input  logic [`HEIGHT_BITS-1:0] y,
    output logic                    keep
);
    localparam logic [`WIDTH_BITS:0]  W_LIM = (`WIDTH_BITS+1)'(`WIDTH);
    localparam logic [`HEIGHT_BITS:0] H_LIM = (`HEIGHT_BITS+1)'(`HEIGHT);

    logic x_ok;
    logic y_ok;

    // A wrapped coordinate lands on the wrong side of the centre.
    always_comb begin
        x_ok = OCT_X_ADD[oct] ? ((x >= xc) && ({1'b0, x} < W_LIM)) : (x <= xc);
        y_ok = OCT_Y_ADD[oct] ? ((y >= yc) && ({1'b0, y} < H_LIM)) : (y <= yc);
        keep = x_ok && y_ok;
    end

endmodule

// File: rtl/gpu_circle_ctrl.sv
// Circle sequencer: walks the octant engine through the masked octants and
// turns its point stream into pixel write strobes.
// Optional macro GPU_CIRCLE_CLIP_EN: drop wrapped / off-screen points.
//
// state  | meaning
// IDLE   | ready for a command
// LAUNCH | engine start raised, watchdog loaded
// RUN    | engine drawing, points captured
// GAP    | start low one cycle, pick next octant
// POINT  | radius zero, single centre pixel
// FINISH | done pulse
`ifndef WIDTH
`define WIDTH 1024
`endif
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT
`define HEIGHT 600
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 10
`endif

module gpu_circle_ctrl
    import gpu_circle_pkg::*;
#(
    parameter int MAX_RAD  = `WIDTH/2,
    parameter int WD_SLACK = 4
)(
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [`WIDTH_BITS-1:0]  xC,
    input  logic [`HEIGHT_BITS-1:0] yC,
    input  logic [`WIDTH_BITS-1:0]  rad,
    input  logic [7:0]              oct_mask,
    output logic [2:0]              eng_oct,
    output logic                    eng_start,
    input  logic                    eng_done,
    input  logic                    eng_busy,
    input  logic [`WIDTH_BITS-1:0]  eng_x,
    input  logic [`HEIGHT_BITS-1:0] eng_y,
    output logic                    px_we,
    output logic [`WIDTH_BITS-1:0]  px_x,
    output logic [`HEIGHT_BITS-1:0] px_y,
    output logic                    done_o,
    output logic                    err_o,
    output logic [15:0]             pix_cnt
);
    localparam int WB = `WIDTH_BITS;
    localparam logic [WB:0] MAX_RAD_W = MAX_RAD[WB:0];
    localparam logic [WB:0] SLACK_W   = WD_SLACK[WB:0];

    circle_state_t state, state_n;
    logic [2:0]              idx, idx_n;
    logic [7:0]              mask_r, mask_n;
    logic [WB-1:0]           xc_r, xc_n;
    logic [`HEIGHT_BITS-1:0] yc_r, yc_n;
    logic [WB-1:0]           rad_r, rad_n;
    logic [WB:0]             wd, wd_n;
    logic                    px_we_n;
    logic [WB-1:0]           px_x_n;
    logic [`HEIGHT_BITS-1:0] px_y_n;
    logic                    err_n;
    logic                    cnt_inc, cnt_clr;
    logic [3:0]              nxt, first;
    logic                    keep;

`ifdef GPU_CIRCLE_CLIP_EN
    gpu_octant_clip u_clip (
        .oct  (idx),
        .xc   (xc_r),
        .yc   (yc_r),
        .x    (eng_x),
        .y    (eng_y),
        .keep (keep)
    );
`else
    assign keep = 1'b1;
`endif

    assign cmd_ready = (state == S_IDLE);
    assign eng_start = (state == S_LAUNCH) || (state == S_RUN);
    assign eng_oct   = idx;
    assign done_o    = (state == S_FINISH);

    // State register and datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            mask_r  <= '0;
            xc_r    <= '0;
            yc_r    <= '0;
            rad_r   <= '0;
            wd      <= '0;
            px_we   <= 1'b0;
            px_x    <= '0;
            px_y    <= '0;
            err_o   <= 1'b0;
            pix_cnt <= '0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            mask_r <= mask_n;
            xc_r   <= xc_n;
            yc_r   <= yc_n;
            rad_r  <= rad_n;
            wd     <= wd_n;
            px_we  <= px_we_n;
            px_x   <= px_x_n;
            px_y   <= px_y_n;
            err_o  <= err_n;
            if (cnt_clr)
                pix_cnt <= '0;
            else if (cnt_inc && (pix_cnt != 16'hFFFF))
                pix_cnt <= pix_cnt + 16'd1;
        end
    end

    // Next-state and next-datapath decode.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        mask_n  = mask_r;
        xc_n    = xc_r;
        yc_n    = yc_r;
        rad_n   = rad_r;
        wd_n    = wd;
        px_we_n = 1'b0;
        px_x_n  = px_x;
        px_y_n  = px_y;
        err_n   = err_o;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        nxt     = next_oct(mask_r, {1'b0, idx} + 4'd1);
        first   = next_oct(oct_mask, 4'd0);
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    xc_n    = xC;
                    yc_n    = yC;
                    rad_n   = rad;
                    mask_n  = oct_mask;
                    idx_n   = first[2:0];
                    cnt_clr = 1'b1;
                    err_n   = 1'b0;
                    if (oct_mask == 8'd0) begin
                        state_n = S_FINISH;
                    end else if ({1'b0, rad} > MAX_RAD_W) begin
                        err_n   = 1'b1;
                        state_n = S_FINISH;
                    end else if (rad == '0) begin
                        state_n = S_POINT;
                    end else begin
                        state_n = S_LAUNCH;
                    end
                end
            end
            S_POINT: begin
                px_we_n = 1'b1;
                px_x_n  = xc_r;
                px_y_n  = yc_r;
                cnt_inc = 1'b1;
                state_n = S_FINISH;
            end
            S_LAUNCH: begin
                wd_n    = {1'b0, rad_r} + SLACK_W;
                state_n = S_RUN;
            end
            S_RUN: begin
                if (eng_busy && keep) begin
                    px_we_n = 1'b1;
                    px_x_n  = eng_x;
                    px_y_n  = eng_y;
                    cnt_inc = 1'b1;
                end
                // Terminal count hits on the last allowed RUN cycle.
                if (eng_done) begin
                    state_n = S_GAP;
                end else if (wd <= (WB+1)'(1)) begin
                    err_n   = 1'b1;
                    state_n = S_FINISH;
                end else begin
                    wd_n = wd - (WB+1)'(1);
                end
            end
            S_GAP: begin
                if (!nxt[3]) begin
                    idx_n   = nxt[2:0];
                    state_n = S_LAUNCH;
                end else begin
                    state_n = S_FINISH;
                end
            end
            S_FINISH: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gpu_circle_ctrl.sv
// Directed bench for gpu_circle_ctrl with a behavioural octant engine.
`ifndef WIDTH
`define WIDTH 1024
`endif
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT
`define HEIGHT 600
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 10
`endif

module tb_gpu_circle_ctrl;

    logic                    clk = 1'b0;
    logic                    n_rst = 1'b0;
    logic                    cmd_valid = 1'b0;
    logic                    cmd_ready;
    logic [`WIDTH_BITS-1:0]  xC = '0;
    logic [`HEIGHT_BITS-1:0] yC = '0;
    logic [`WIDTH_BITS-1:0]  rad = '0;
    logic [7:0]              oct_mask = '0;
    logic [2:0]              eng_oct;
    logic                    eng_start;
    logic                    eng_done = 1'b0;
    logic                    eng_busy = 1'b0;
    logic [`WIDTH_BITS-1:0]  eng_x = '0;
    logic [`HEIGHT_BITS-1:0] eng_y = '0;
    logic                    px_we;
    logic [`WIDTH_BITS-1:0]  px_x;
    logic [`HEIGHT_BITS-1:0] px_y;
    logic                    done_o;
    logic                    err_o;
    logic [15:0]             pix_cnt;

    gpu_circle_ctrl dut (
        .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .xC(xC), .yC(yC), .rad(rad), .oct_mask(oct_mask),
        .eng_oct(eng_oct), .eng_start(eng_start), .eng_done(eng_done), .eng_busy(eng_busy),
        .eng_x(eng_x), .eng_y(eng_y), .px_we(px_we), .px_x(px_x), .px_y(px_y),
        .done_o(done_o), .err_o(err_o), .pix_cnt(pix_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Midpoint points of one octant for the current radius.
    int pu[400];
    int pv[400];
    int npts = 0;
    int cx = 0, cy = 0;
    bit hang = 1'b0;

    task automatic compute_pts(input int r);
        int x, y, d;
        x = r; y = 0; d = 1 - r; npts = 0;
        while (y <= x && npts < 400) begin
            pu[npts] = x; pv[npts] = y; npts++;
            y++;
            if (d < 0) d = d + 2*y + 1;
            else begin x--; d = d + 2*(y - x) + 1; end
        end
    endtask

    // Engine model: restarts on each rising eng_start, one point per cycle, then done.
    int m_idx = 0;
    bit m_fin = 1'b0;
    int e_dx, e_dy;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst || !eng_start) begin
            eng_busy <= 1'b0; eng_done <= 1'b0; m_idx <= 0; m_fin <= 1'b0;
        end else if (m_fin) begin
            eng_busy <= 1'b0; eng_done <= 1'b0;
        end else if (m_idx < npts) begin
            case (eng_oct)
                3'd0: begin e_dx =  pu[m_idx]; e_dy = -pv[m_idx]; end
                3'd1: begin e_dx =  pv[m_idx]; e_dy = -pu[m_idx]; end
                3'd2: begin e_dx = -pv[m_idx]; e_dy = -pu[m_idx]; end
                3'd3: begin e_dx = -pu[m_idx]; e_dy = -pv[m_idx]; end
                3'd4: begin e_dx = -pu[m_idx]; e_dy =  pv[m_idx]; end
                3'd5: begin e_dx = -pv[m_idx]; e_dy =  pu[m_idx]; end
                3'd6: begin e_dx =  pv[m_idx]; e_dy =  pu[m_idx]; end
                default: begin e_dx = pu[m_idx]; e_dy = pv[m_idx]; end
            endcase
            eng_busy <= 1'b1; eng_done <= 1'b0;
            eng_x <= `WIDTH_BITS'(cx + e_dx);
            eng_y <= `HEIGHT_BITS'(cy + e_dy);
            m_idx <= m_idx + 1;
        end else begin
            eng_busy <= 1'b0;
            eng_done <= !hang;
            m_fin    <= !hang;
        end
    end

    // Output monitor.
    int pxq[$];
    int pyq[$];
    int lq[$];
    int gq[$];
    int hq[$];
    int done_cnt = 0;
    bit st_prev = 1'b0;
    bit seen = 1'b0;
    int lo_len = 0, hi_len = 0;
    always @(negedge clk) begin
        if (px_we) begin pxq.push_back(int'(px_x)); pyq.push_back(int'(px_y)); end
        if (done_o) done_cnt++;
        if (eng_start && !st_prev) begin
            lq.push_back(int'(eng_oct));
            if (seen) gq.push_back(lo_len);
            seen = 1'b1; hi_len = 1;
        end else if (eng_start) hi_len++;
        if (!eng_start && st_prev) begin hq.push_back(hi_len); lo_len = 1; end
        else if (!eng_start) lo_len++;
        st_prev = eng_start;
    end

    typedef struct {
        int xc; int yc; int rad; logic [7:0] mask; bit hang;
        int pix; int nl; int err; int fx; int fy; int hi;
    } vec_t;

    vec_t tv[8];

    task automatic run_cmd(input int n, input vec_t v);
        int t;
        @(posedge clk); #1;
        cx = v.xc; cy = v.yc; hang = v.hang;
        compute_pts(v.rad);
        pxq.delete(); pyq.delete(); lq.delete(); gq.delete(); hq.delete();
        done_cnt = 0; seen = 1'b0;
        xC = `WIDTH_BITS'(v.xc); yC = `HEIGHT_BITS'(v.yc);
        rad = `WIDTH_BITS'(v.rad); oct_mask = v.mask; cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 100) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk($sformatf("v%0d_start_after_accept", n), int'(eng_start), (v.nl != 0) ? 1 : 0);
        t = 0;
        while (done_cnt == 0 && t < 3000) begin @(posedge clk); #1; t++; end
        chk($sformatf("v%0d_done_seen", n), (done_cnt != 0) ? 1 : 0, 1);
        chk($sformatf("v%0d_ready_after_done", n), int'(cmd_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("v%0d_done_pulses", n), done_cnt, 1);
        chk($sformatf("v%0d_pix_cnt", n), int'(pix_cnt), v.pix);
        chk($sformatf("v%0d_px_we_count", n), pxq.size(), v.pix);
        chk($sformatf("v%0d_err", n), int'(err_o), v.err);
        chk($sformatf("v%0d_launches", n), lq.size(), v.nl);
    endtask

    initial begin
        int ord[$];
        int e, wraps, over;
        // xc yc rad mask hang | pix launches err first_x first_y start_high_len
        tv[0] = '{100, 100,   5, 8'h01, 1'b0,  4, 1, 0,  105, 100,  6};
        tv[1] = '{300, 200,  10, 8'hFF, 1'b0, 64, 8, 0,  310, 200,  0};
        tv[2] = '{400, 300,   0, 8'hFF, 1'b0,  1, 0, 0,  400, 300,  0};
        tv[3] = '{200, 300,   5, 8'h24, 1'b0,  8, 2, 0,  200, 295,  0};
        tv[4] = '{ 50,  60,   6, 8'h01, 1'b1,  5, 1, 1,   56,  60, 11};
        tv[5] = '{ 10,  10, 513, 8'h01, 1'b0,  0, 0, 1,    0,   0,  0};
        tv[6] = '{ 10,  10,   5, 8'h00, 1'b0,  0, 0, 0,    0,   0,  0};
`ifdef GPU_CIRCLE_CLIP_EN
        tv[7] = '{  2,  50,   8, 8'h18, 1'b0,  0, 2, 0,    0,   0,  0};
`else
        tv[7] = '{  2,  50,   8, 8'h18, 1'b0, 12, 2, 0, 1018,  50,  0};
`endif

        #1;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_eng_start", int'(eng_start), 0);
        chk("rst_eng_oct",   int'(eng_oct), 0);
        chk("rst_px_we",     int'(px_we), 0);
        chk("rst_px_x",      int'(px_x), 0);
        chk("rst_px_y",      int'(px_y), 0);
        chk("rst_done",      int'(done_o), 0);
        chk("rst_err",       int'(err_o), 0);
        chk("rst_pix_cnt",   int'(pix_cnt), 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        // Reset asserted while the engine is running.
        @(posedge clk); #1;
        cx = 300; cy = 200; hang = 1'b0; compute_pts(10);
        xC = 10'd300; yC = 10'd200; rad = 10'd10; oct_mask = 8'hFF; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        begin
            int t;
            t = 0;
            while (!(eng_start && eng_busy) && t < 50) begin @(posedge clk); #1; t++; end
        end
        repeat (3) @(posedge clk);
        #2;
        chk("midrun_eng_start", int'(eng_start), 1);
        n_rst = 1'b0;
        #1;
        chk("midrst_eng_start", int'(eng_start), 0);
        chk("midrst_px_we", int'(px_we), 0);
        chk("midrst_done", int'(done_o), 0);
        chk("midrst_pix_cnt", int'(pix_cnt), 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
        chk("postrst_cmd_ready", int'(cmd_ready), 1);
        chk("postrst_eng_start", int'(eng_start), 0);

        for (int i = 0; i < 8; i++) begin
            run_cmd(i, tv[i]);
            if (tv[i].pix > 0 && pxq.size() > 0) begin
                chk($sformatf("v%0d_first_x", i), pxq[0], tv[i].fx);
                chk($sformatf("v%0d_first_y", i), pyq[0], tv[i].fy);
            end
            ord.delete();
            for (int b = 0; b < 8; b++) if (tv[i].mask[b] && tv[i].nl > 0) ord.push_back(b);
            if (tv[i].nl > 0 && !tv[i].hang) begin
                chk($sformatf("v%0d_gap_count", i), gq.size(), tv[i].nl - 1);
                for (int k = 0; k < lq.size() && k < ord.size(); k++)
                    chk($sformatf("v%0d_launch%0d_oct", i, k), lq[k], ord[k]);
                for (int k = 0; k < gq.size(); k++)
                    chk($sformatf("v%0d_gap%0d_len", i, k), gq[k], 1);
            end
            if (tv[i].hi != 0 && hq.size() > 0)
                chk($sformatf("v%0d_start_high_len", i), hq[0], tv[i].hi);
            if (tv[i].mask == 8'hFF && tv[i].rad > 0) begin
                over = 0;
                for (int k = 0; k < pxq.size(); k++) begin
                    e = (pxq[k]-tv[i].xc)*(pxq[k]-tv[i].xc) + (pyq[k]-tv[i].yc)*(pyq[k]-tv[i].yc)
                        - tv[i].rad*tv[i].rad;
                    if (e > 10 || e < -10) over++;
                end
                chk($sformatf("v%0d_radius_err_pixels", i), over, 0);
            end
            if (tv[i].mask == 8'h18) begin
                wraps = 0;
                for (int k = 0; k < pxq.size(); k++) if (pxq[k] > 2) wraps++;
`ifdef GPU_CIRCLE_CLIP_EN
                chk("clip_no_px_x_gt_2", wraps, 0);
`else
                chk("noclip_wrapped_px", wraps, 12);
`endif
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
